// File: rtl/ps2_keycode_receiver_pkg.sv
// Shared definitions for the PS/2 keycode receiver: FSM encoding, prefix codes
// and the layout of a buffered key event.
package ps2_keycode_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int KEY_W        = 10;
  localparam int KEY_CODE_LSB = 0;
  localparam int KEY_BRK_BIT  = 8;
  localparam int KEY_EXT_BIT  = 9;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Synchronous show-ahead FIFO for decoded key events; head reads as zero when empty.
module ps2_key_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_keycode_receiver.sv
// Oversampling PS/2 keyboard receiver: sync, glitch filter, frame FSM, prefix
// folding, sticky error flags and a key-event FIFO.
module ps2_keycode_receiver
  import ps2_keycode_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       iKeyRead,
  input  logic       iClearError,
  output logic [7:0] oKeyCode,
  output logic       oKeyBreak,
  output logic       oKeyExtended,
  output logic       oFifoEmpty,
  output logic       oFifoFull,
  output logic       oParityError,
  output logic       oFrameError,
  output logic       oOverflow
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic             clk_s_p0, clk_s_p1, dat_s_p0, dat_s_p1;
  logic [FCW-1:0]   filt_cnt;
  logic             clk_filt, clk_filt_d, fall_p2;
  ps2_state_e       state_q, state_d;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [TW-1:0]    idle_cnt;
  logic             timeout, frame_done, parity_ok;
  logic             push_set, perr_set, ferr_set, ovf_set;
  logic             pend_ext, pend_brk;
  logic             push_p3;
  logic [KEY_W-1:0] push_data_p3, head;
  logic             fifo_full, fifo_empty;

  // Stage p0/p1: two-flop synchronisers; idle-high line resets to 1
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_s_p0 <= 1'b1;
      clk_s_p1 <= 1'b1;
      dat_s_p0 <= 1'b1;
      dat_s_p1 <= 1'b1;
    end else begin
      clk_s_p0 <= PS2_CLK;
      clk_s_p1 <= clk_s_p0;
      dat_s_p0 <= PS2_DATA;
      dat_s_p1 <= dat_s_p0;
    end
  end

  // Stage p2: glitch filter and registered falling-edge strobe
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      fall_p2    <= 1'b0;
    end else begin
      clk_filt_d <= clk_filt;
      fall_p2    <= clk_filt_d & ~clk_filt;
      if (clk_s_p1 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        clk_filt <= clk_s_p1;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end
  end

  // Stage p3: frame FSM, evaluated on each falling-edge strobe
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    timeout    = (state_q != ST_IDLE) && !fall_p2 && (idle_cnt == TW'(TIMEOUT_CYCLES));
    case (state_q)
      ST_IDLE:   if (fall_p2 && !dat_s_p1) state_d = ST_DATA;
      ST_DATA:   if (fall_p2 && bit_cnt == 3'd7) state_d = ST_PARITY;
      ST_PARITY: if (fall_p2) state_d = ST_STOP;
      ST_STOP: begin
        if (fall_p2) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_IDLE;
  end

  assign parity_ok = odd_parity_ok(shreg, par_bit);
  assign ferr_set  = (frame_done && !dat_s_p1) || timeout;
  assign perr_set  = frame_done && dat_s_p1 && !parity_ok;
  assign push_set  = frame_done && dat_s_p1 && parity_ok &&
                     (shreg != PS2_EXT) && (shreg != PS2_BREAK);
  assign ovf_set   = push_p3 && fifo_full && !iKeyRead;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) bit_cnt <= '0;
      else if (state_q == ST_DATA && fall_p2) bit_cnt <= bit_cnt + 3'd1;
      if (state_q == ST_IDLE || fall_p2) idle_cnt <= '0;
      else if (!timeout) idle_cnt <= idle_cnt + TW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (fall_p2 && state_q == ST_DATA)   shreg   <= {dat_s_p1, shreg[7:1]};
    if (fall_p2 && state_q == ST_PARITY) par_bit <= dat_s_p1;
    if (push_set) push_data_p3 <= {pend_ext, pend_brk, shreg};
  end

  // Prefix folding, push strobe and sticky flags; a fresh error beats a clear
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_ext     <= 1'b0;
      pend_brk     <= 1'b0;
      push_p3      <= 1'b0;
      oParityError <= 1'b0;
      oFrameError  <= 1'b0;
      oOverflow    <= 1'b0;
    end else begin
      push_p3 <= push_set;
      if (frame_done && dat_s_p1) begin
        if (!parity_ok || push_set) begin
          pend_ext <= 1'b0;
          pend_brk <= 1'b0;
        end else if (shreg == PS2_EXT) begin
          pend_ext <= 1'b1;
        end else begin
          pend_brk <= 1'b1;
        end
      end
      oParityError <= perr_set | (oParityError & ~iClearError);
      oFrameError  <= ferr_set | (oFrameError & ~iClearError);
      oOverflow    <= ovf_set  | (oOverflow & ~iClearError);
    end
  end

  ps2_key_fifo #(
    .WIDTH(KEY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .push   (push_p3),
    .pop    (iKeyRead),
    .wdata  (push_data_p3),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign oKeyCode     = head[KEY_CODE_LSB +: 8];
  assign oKeyBreak    = head[KEY_BRK_BIT];
  assign oKeyExtended = head[KEY_EXT_BIT];
  assign oFifoEmpty   = fifo_empty;
  assign oFifoFull    = fifo_full;

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Randomised PS/2 frame bench with a queue-based key-event model and directed corner cases.
module tb_ps2_keycode_receiver;

  localparam int FL    = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 400;
  localparam int HALF  = 16;

  logic       Clock, Reset_n, PS2_CLK, PS2_DATA, iKeyRead, iClearError;
  logic [7:0] oKeyCode;
  logic       oKeyBreak, oKeyExtended, oFifoEmpty, oFifoFull;
  logic       oParityError, oFrameError, oOverflow;

  ps2_keycode_receiver #(
    .FILTER_LEN(FL),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .iKeyRead(iKeyRead), .iClearError(iClearError),
    .oKeyCode(oKeyCode), .oKeyBreak(oKeyBreak), .oKeyExtended(oKeyExtended),
    .oFifoEmpty(oFifoEmpty), .oFifoFull(oFifoFull),
    .oParityError(oParityError), .oFrameError(oFrameError), .oOverflow(oOverflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;
  bit settled = 1'b0;

  // Model: queue of {ext, brk, code} entries plus prefix and sticky flags
  logic [9:0] mq[$];
  bit m_ext, m_brk, m_perr, m_ferr, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_frame(input logic [7:0] b, input bit bad_par,
                                      input bit bad_stop, input bit popsync);
    if (popsync && mq.size() > 0) void'(mq.pop_front());
    if (bad_stop) m_ferr = 1;
    else if (bad_par) begin
      m_perr = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ext = 0; m_brk = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
  endfunction

  always @(negedge Clock) begin
    if (settled) begin
      chk("empty", 32'(oFifoEmpty), 32'(mq.size() == 0));
      chk("full", 32'(oFifoFull), 32'(mq.size() == DEPTH));
      chk("parity_err", 32'(oParityError), 32'(m_perr));
      chk("frame_err", 32'(oFrameError), 32'(m_ferr));
      chk("overflow", 32'(oOverflow), 32'(m_ovf));
      if (mq.size() > 0)
        chk("head", 32'({oKeyExtended, oKeyBreak, oKeyCode}), 32'(mq[0]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic ps2_bit(input logic v, input bit glitch);
    PS2_DATA = v;
    cyc(HALF / 2);
    if (glitch) begin
      PS2_CLK = 1'b0;
      cyc(1);
      PS2_CLK = 1'b1;
    end
    cyc(HALF / 2);
    PS2_CLK = 1'b0;
    cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  // lat=1 probes the empty flag around the push, lat=2 the parity flag
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit popsync, input int glitch_bit, input int lat);
    logic [10:0] bits;
    logic p;
    settled = 1'b0;
    p = ~^b;
    if (bad_par) p = ~p;
    bits = {~bad_stop, p, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i], i == glitch_bit);
    PS2_DATA = bits[10];
    cyc(HALF);
    PS2_CLK = 1'b0;
    for (int n = 1; n <= HALF; n++) begin
      @(posedge Clock);
      #1;
      if (popsync) iKeyRead = (n == FL + 4);
      if (lat == 1 && (n == FL + 4 || n == FL + 5)) begin
        @(negedge Clock);
        chk("empty_latency", 32'(oFifoEmpty), 32'(n == FL + 4));
      end
      if (lat == 2 && (n == FL + 3 || n == FL + 4)) begin
        @(negedge Clock);
        chk("perr_latency", 32'(oParityError), 32'(n == FL + 4));
      end
    end
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    cyc(FL + 8);
    model_frame(b, bad_par, bad_stop, popsync);
    settled = 1'b1;
  endtask

  task automatic send_partial(input int nbits);
    settled = 1'b0;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    PS2_DATA = 1'b1;
  endtask

  task automatic pop_key();
    iKeyRead = 1'b1;
    cyc(1);
    iKeyRead = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clear_err();
    iClearError = 1'b1;
    cyc(1);
    iClearError = 1'b0;
    m_perr = 0; m_ferr = 0; m_ovf = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_empty"}, 32'(oFifoEmpty), 32'd1);
    chk({tag, "_full"}, 32'(oFifoFull), 32'd0);
    chk({tag, "_code"}, 32'(oKeyCode), 32'd0);
    chk({tag, "_brkext"}, 32'({oKeyBreak, oKeyExtended}), 32'd0);
    chk({tag, "_errs"}, 32'({oParityError, oFrameError, oOverflow}), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    Reset_n = 1'b0; PS2_CLK = 1'b1; PS2_DATA = 1'b1;
    iKeyRead = 1'b0; iClearError = 1'b0;
    model_reset();
    cyc(3);
    chk_reset_outputs("reset");
    Reset_n = 1'b1;
    cyc(2);
    settled = 1'b1;

    // Plain make code with latency probe
    send_frame(8'h1C, 0, 0, 0, -1, 1);
    chk("t1_code", 32'({oKeyExtended, oKeyBreak, oKeyCode}), 32'h01C);
    pop_key();

    // Prefix folding
    send_frame(8'hF0, 0, 0, 0, -1, 0);
    send_frame(8'h1C, 0, 0, 0, -1, 0);
    send_frame(8'hE0, 0, 0, 0, -1, 0);
    send_frame(8'hF0, 0, 0, 0, -1, 0);
    send_frame(8'h75, 0, 0, 0, -1, 0);
    chk("t2_first", 32'({oKeyExtended, oKeyBreak, oKeyCode}), 32'h11C);
    pop_key();
    cyc(1);
    chk("t2_second", 32'({oKeyExtended, oKeyBreak, oKeyCode}), 32'h375);
    pop_key();

    // Bad parity, then clear
    send_frame(8'h1C, 1, 0, 0, -1, 2);
    chk("t3_perr", 32'({oParityError, oFifoEmpty}), 32'b11);
    clear_err();
    @(negedge Clock);
    chk("t3_cleared", 32'(oParityError), 32'd0);
    cyc(1);

    // Push with a pop while empty keeps the push
    send_frame(8'h1C, 0, 0, 1, -1, 0);
    chk("t4_push_only", 32'({oFifoEmpty, oKeyCode}), 32'h01C);
    pop_key();

    // Fill, overflow, then push+pop while full
    send_frame(8'h15, 0, 0, 0, -1, 0);
    send_frame(8'h16, 0, 0, 0, -1, 0);
    send_frame(8'h1E, 0, 0, 0, -1, 0);
    send_frame(8'h26, 0, 0, 0, -1, 0);
    send_frame(8'h25, 0, 0, 0, -1, 0);
    chk("t5_full_ovf", 32'({oFifoFull, oOverflow}), 32'b11);
    clear_err();
    send_frame(8'h2E, 0, 0, 1, -1, 0);
    chk("t5_swap", 32'({oFifoFull, oOverflow, oKeyCode}), 32'h216);
    for (int i = 0; i < DEPTH; i++) pop_key();

    // Timeout mid-frame keeps a pending extended prefix
    send_frame(8'hE0, 0, 0, 0, -1, 0);
    send_partial(3);
    cyc(TMO + 40);
    m_ferr = 1;
    settled = 1'b1;
    @(negedge Clock);
    chk("t6_ferr", 32'(oFrameError), 32'd1);
    cyc(1);
    send_frame(8'h29, 0, 0, 0, -1, 0);
    chk("t6_after", 32'({oKeyExtended, oKeyBreak, oKeyCode}), 32'h229);
    pop_key();
    clear_err();

    // Clock glitch inside a data bit
    send_frame(8'h5A, 0, 0, 0, 4, 0);
    chk("t7_glitch", 32'({oFifoEmpty, oKeyCode}), 32'h05A);

    // Reset mid-frame with an entry and an error pending
    send_frame(8'h33, 0, 1, 0, -1, 0);
    send_partial(2);
    Reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    cyc(2);
    Reset_n = 1'b1;
    cyc(2);
    settled = 1'b1;

    // Randomised traffic
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else b = 8'($urandom);
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0, 0, -1, 0);
      if ($urandom_range(0, 2) == 0) pop_key();
      if ($urandom_range(0, 3) == 0) pop_key();
      if ($urandom_range(0, 7) == 0) clear_err();
      cyc(1);
    end

    settled = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
